// File: rtl/s_axi_read_responder_if.sv
// AXI4-Lite read-channel bundle (AR + R) for the DFX sequencer register responder.
interface s_axi_read_responder_if #(
  parameter int unsigned GLOB_ADDR_WIDTH = 32,
  parameter int unsigned GLOB_DATA_WIDTH = 32
);
  logic [GLOB_ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                       S_AXI_ARVALID;
  logic                       S_AXI_ARREADY;
  logic [GLOB_DATA_WIDTH-1:0] S_AXI_RDATA;
  logic [1:0]                 S_AXI_RRESP;
  logic                       S_AXI_RVALID;
  logic                       S_AXI_RREADY;

  modport slave (
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/s_axi_read_responder.sv
// AXI4-Lite read responder: decodes bank0 registers and bank1 slot fields, one
// transaction outstanding, one R beat per AR.
module s_axi_read_responder #(
  parameter int unsigned GLOB_ADDR_WIDTH     = 32,
  parameter int unsigned GLOB_DATA_WIDTH     = 32,
  parameter int unsigned BANK1_INDEX_WIDTH   = 2,
  parameter int unsigned BANK0_CONTROL_WIDTH = 4,
  parameter int unsigned BANK0_STATUS_WIDTH  = 4,
  parameter int unsigned BANK0_CNT_WIDTH     = BANK1_INDEX_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  s_axi_read_responder_if.slave          s_axi,
  input  logic [BANK0_CONTROL_WIDTH-1:0] bank0_control,
  input  logic [BANK0_STATUS_WIDTH-1:0]  bank0_status,
  input  logic [BANK0_CNT_WIDTH-1:0]     bank0_cnt,
  output logic                           bank1_rd_en,
  output logic [BANK1_INDEX_WIDTH-1:0]   bank1_rd_slot,
  output logic [2:0]                     bank1_rd_field,
  input  logic [GLOB_DATA_WIDTH-1:0]     bank1_rd_data
);

  localparam int unsigned SlotLsb   = 5;
  localparam int unsigned HiLsb     = SlotLsb + BANK1_INDEX_WIDTH;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {StIdle, StDecode, StFetch, StResp} state_e;

  state_e                       state_q;
  logic                         arready_q;
  logic                         rvalid_q;
  logic [GLOB_DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]                   rresp_q;
  logic                         rd_en_q;
  logic [BANK1_INDEX_WIDTH-1:0] rd_slot_q;
  logic [2:0]                   rd_field_q;
  logic [12:2]                  addr_q;
  logic                         b1_hit_q;

  logic                         ar_hs;
  logic [2:0]                   ar_field;
  logic [BANK1_INDEX_WIDTH-1:0] ar_slot;
  logic                         ar_b1_hit;
  logic                         unused_addr_bits;

  assign ar_hs     = s_axi.S_AXI_ARVALID && arready_q;
  assign ar_field  = s_axi.S_AXI_ARADDR[4:2];
  assign ar_slot   = s_axi.S_AXI_ARADDR[HiLsb-1:SlotLsb];
  assign ar_b1_hit = s_axi.S_AXI_ARADDR[12] && (ar_field < 3'd6) &&
                     (s_axi.S_AXI_ARADDR[11:HiLsb] == '0);

  // Byte-lane bits and everything above the bank select alias freely.
  assign unused_addr_bits = ^{s_axi.S_AXI_ARADDR[GLOB_ADDR_WIDTH-1:13],
                              s_axi.S_AXI_ARADDR[1:0]};

  // The bank1 strobe is launched on the AR edge so it is high during DECODE and
  // the one-cycle-latency slot data is ready to capture at the end of FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
      rd_en_q    <= 1'b0;
      rd_slot_q  <= '0;
      rd_field_q <= '0;
      addr_q     <= '0;
      b1_hit_q   <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ar_hs) begin
            arready_q <= 1'b0;
            addr_q    <= s_axi.S_AXI_ARADDR[12:2];
            b1_hit_q  <= ar_b1_hit;
            if (ar_b1_hit) begin
              rd_en_q    <= 1'b1;
              rd_slot_q  <= ar_slot;
              rd_field_q <= ar_field;
            end
            state_q <= StDecode;
          end else begin
            arready_q <= 1'b1;
          end
        end
        StDecode: begin
          if (addr_q[12] && b1_hit_q) begin
            state_q <= StFetch;
          end else begin
            rvalid_q <= 1'b1;
            state_q  <= StResp;
            rresp_q  <= RespOkay;
            if (addr_q[12]) begin
              rdata_q <= '0;
              rresp_q <= RespSlvErr;
            end else begin
              case (addr_q[11:2])
                10'd0:   rdata_q <= GLOB_DATA_WIDTH'(bank0_control);
                10'd1:   rdata_q <= GLOB_DATA_WIDTH'(bank0_status);
                10'd2:   rdata_q <= GLOB_DATA_WIDTH'(bank0_cnt);
                default: begin
                  rdata_q <= '0;
                  rresp_q <= RespSlvErr;
                end
              endcase
            end
          end
        end
        StFetch: begin
          rdata_q  <= bank1_rd_data;
          rresp_q  <= RespOkay;
          rvalid_q <= 1'b1;
          state_q  <= StResp;
        end
        StResp: begin
          if (s_axi.S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign bank1_rd_en         = rd_en_q;
  assign bank1_rd_slot       = rd_slot_q;
  assign bank1_rd_field      = rd_field_q;

endmodule
